// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding uart_fd: buffers host writes and launches them one at a
// time with a tx_start pulse, using tx_busy as the return handshake.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_idle,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [TW-1:0]     timer;
  logic              push, pop;
  logic [AW:0]       count_nxt;

  // A write while full is dropped regardless of a same-cycle pop.
  always_comb begin
    push      = wr_en && !full;
    pop       = (state == IDLE) && !empty && !tx_busy;
    count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_ && push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == FULL_CNT);
      empty    <= (count_nxt == '0);
      overflow <= wr_en && full;
    end
  end

  // tx_idle is computed from next-state values so it lines up with empty and state.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_idle  <= 1'b1;
      timer    <= '0;
    end else begin
      tx_start <= 1'b0;
      tx_idle  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end else begin
            tx_idle  <= (count_nxt == '0);
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A missing busy response consumes the byte; it is not retried.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == T_LAST) begin
            state   <= IDLE;
            tx_idle <= (count_nxt == '0);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state   <= IDLE;
            tx_idle <= (count_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue model of the FIFO plus a simple uart_fd
// busy responder; a negedge monitor compares every launch and the occupancy flags.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16, DATA_W = 8, BUSY_TIMEOUT = 4;

  logic                   clk = 1'b0, rst_ = 1'b1, wr_en = 1'b0, tx_busy = 1'b0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   full, empty, overflow, tx_idle, tx_start;
  logic [$clog2(DEPTH):0] count;
  logic [DATA_W-1:0]      tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .tx_idle(tx_idle),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // uart_fd stand-in: busy rises the cycle after it samples tx_start, lasts busy_len cycles.
  int busy_len = 2, busy_left = 0;
  bit busy_force = 0, launch_prev = 0;
  initial forever begin
    @(posedge clk); #2;
    if (busy_left > 0) busy_left--;
    if (launch_prev && busy_len > 0) busy_left = busy_len;
    tx_busy = busy_force || (busy_left > 0);
    launch_prev = tx_start;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected byte order and occupancy.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] held_data = '0;
  int model_count = 0, ovf_seen = 0;
  bit rst_pending = 1, push_pending = 0, ovf_pending = 0, prev_start = 0;
  int unsigned push_edge = 0, start_edge = 0;
  int unsigned start_q[$];

  initial forever begin
    @(negedge clk);
    if (rst_pending) begin
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_idle", tx_idle, 1);
      model_count = 0;
      exp_q.delete();
      held_data = '0;
    end else begin
      model_count += int'(push_pending);
      if (tx_start) begin
        check("start_single_cycle", prev_start, 0);
        check("start_has_expected_byte", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          held_data = exp_q.pop_front();
          check("tx_data_order", tx_data, held_data);
          model_count--;
        end
        start_edge = cyc + 1;
        start_q.push_back(cyc + 1);
      end else begin
        check("tx_data_hold", tx_data, held_data);
      end
      check("count", count, model_count);
      check("full", full, model_count == DEPTH);
      check("empty", empty, model_count == 0);
      check("overflow", overflow, ovf_pending);
      if (overflow) ovf_seen++;
    end
    prev_start   = tx_start;
    rst_pending  = rst_;
    push_pending = !rst_ && wr_en && model_count < DEPTH;
    ovf_pending  = !rst_ && wr_en && model_count == DEPTH;
    if (push_pending) begin
      exp_q.push_back(wr_data);
      push_edge = cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
    repeat (3) tick();
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    repeat (8) tick();
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_tx_idle"}, tx_idle, 1);
    check({tag, "_count_zero"}, count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, written, ovf0;
    // Reset, then idle with no writes
    tick(); tick();
    rst_ = 1'b0;
    repeat (10) tick();
    check("idle_tx_idle", tx_idle, 1);
    check("idle_count", count, 0);
    check("idle_starts", start_q.size(), 0);

    // Single byte: latency and hold through busy
    busy_len = 10;
    put(8'hA5);
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    check("single_busy_seen", tx_busy, 1);
    check("single_hold_a5", tx_data, 8'hA5);
    check("single_latency", start_edge - push_edge, 2);
    drain("single");

    // Burst 01..10 while stalled, then release
    busy_force = 1; tick(); tick();
    for (int i = 1; i <= DEPTH; i++) put(DATA_W'(i));
    check("burst_full", full, 1);
    check("burst_count", count, DEPTH);
    busy_len = int'($urandom_range(1, 4));
    busy_force = 0;
    drain("burst");

    // Overflow: 17 writes with busy held
    busy_force = 1; tick(); tick();
    ovf0 = ovf_seen;
    for (int i = 0; i < DEPTH; i++) put(DATA_W'($urandom_range(0, 8'hED)));
    put(8'hEE);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, DEPTH);
    tick();
    check("ovf_pulse_end", overflow, 0);
    check("ovf_once", ovf_seen - ovf0, 1);
    busy_len = int'($urandom_range(1, 3));
    busy_force = 0;
    drain("overflow");

    // Low occupancy streaming across pointer wraps
    busy_len = 1;
    written = 0; n = 0;
    while (written < 40 && n < 3000) begin
      if (exp_q.size() < 3 && $urandom_range(0, 3) != 0) begin
        put(DATA_W'($urandom)); written++;
      end else tick();
      n++;
    end
    check("wrap_written", written, 40);
    drain("wrap");

    // Busy never answers: each launch times out
    busy_len = 0;
    start_q.delete();
    for (int i = 0; i < 4; i++) put(DATA_W'($urandom));
    drain("timeout");
    check("timeout_launches", start_q.size(), 4);
    for (int i = 1; i < 4 && i < start_q.size(); i++)
      check("timeout_gap", start_q[i] - start_q[i-1], 1 + BUSY_TIMEOUT + 1);

    // Reset while in WAIT_DONE abandons everything
    busy_len = 8;
    for (int i = 0; i < 3; i++) put(DATA_W'($urandom));
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    check("rstmid_busy_seen", tx_busy, 1);
    tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    check("rstmid_count", count, 0);
    check("rstmid_empty", empty, 1);
    check("rstmid_tx_start", tx_start, 0);
    start_q.delete();
    repeat (30) tick();
    check("rstmid_no_launch", start_q.size(), 0);
    check("rstmid_tx_idle", tx_idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer that sits directly upstream of uart_fd and drives its tx_start/tx_data inputs.
- Accepts bytes from a host/bus at full clock rate into a DEPTH-entry FIFO.
- Launches them one at a time into uart_fd, using tx_busy as the flow-control return.
- Decouples bursty producers from the 115200-baud serializer.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, at least 2.
- DATA_W, 8, byte width; must match uart_fd tx_data.
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a tx_start pulse.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_  input  1  synchronous reset, active-high.
- wr_en  input  1  host write strobe.
- wr_data  input  DATA_W  host byte.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_idle  output  1  empty and FSM in IDLE (all bytes handed off and finished).
- tx_busy  input  1  from uart_fd; high while it is serializing a frame.
- tx_start  output  1  to uart_fd; one-cycle launch pulse.
- tx_data  output  DATA_W  to uart_fd; byte being sent.

Behaviour:
- Reset (rst_=1 at posedge), with all outputs registered:
  - rd/wr pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, tx_idle=1, FSM=IDLE.
  - Reset mid-transmission abandons the current byte and all queued bytes; uart_fd is not signalled.
- Write:
  - wr_en=1 with full=0 stores wr_data at the write pointer; count increments at the next edge.
  - wr_en=1 with full=1 drops the byte, leaves pointers unchanged, and pulses overflow=1 for exactly the next cycle.
  - A write while full is dropped even if a pop occurs in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full = (count==DEPTH), empty = (count==0); both derived from registered count.
- Simultaneous write (not full) and pop: count unchanged, both pointers advance.
- FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE:
  - IDLE: if empty=0 and tx_busy=0, pop the head into the tx_data register, advance the read pointer, decrement count, go to LAUNCH.
  - LAUNCH: tx_start=1 for this single cycle, with tx_data valid; go to WAIT_BUSY.
  - WAIT_BUSY: tx_busy=1 goes to WAIT_DONE. After BUSY_TIMEOUT cycles without tx_busy, return to IDLE; the byte counts as consumed and is not retried.
  - WAIT_DONE: tx_busy=0 goes to IDLE.
- Latency:
  - A byte written into an empty FIFO while idle appears on tx_start two cycles after the write edge: write edge N, pop at N+1, tx_start high during N+2.
- Gap and hold rules:
  - Minimum gap between consecutive tx_start pulses is one IDLE cycle after tx_busy falls.
  - tx_data holds stable from LAUNCH until the next pop; it never changes while tx_busy=1.
- Ordering: strictly FIFO, no reordering or duplication.
- tx_idle = empty & (FSM==IDLE), registered.

Test Plan:
- Reset then idle: rst_=1 for 2 cycles → count=0, empty=1, tx_idle=1, tx_start never asserts with no writes.
- Single byte: write 8'hA5, model tx_busy high 1 cycle after tx_start for 10 cycles.
  - Expect tx_start high for exactly one cycle, two cycles after the write.
  - Expect tx_data=8'hA5 held through busy; tx_idle=1 after busy falls.
- Burst order: write 8'h01..8'h10 back-to-back (16 bytes) with busy model stalling → full=1 after the 16th write.
  - Expect 16 tx_start pulses carrying 8'h01..8'h10 in order; count returns to 0.
- Overflow: with tx_busy held high, write 17 bytes.
  - Expect the 17th dropped, overflow pulses once, count=16.
  - After release, 16 bytes drain; the 17th byte never appears.
- Simultaneous push/pop and wrap: keep occupancy 1–3 while writing 40 bytes.
  - Expect the pointers to wrap twice, count never errs, output order intact.
- Timeout and reset mid-op:
  - tx_busy tied 0 → each tx_start is followed by a return to IDLE after 4 cycles and the next byte launches.
  - Assert rst_ during WAIT_DONE → next cycle count=0, empty=1, tx_start=0.
